cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle control sequencer for the 8-bit processor datapath. Fetches one 8-bit instruction per handshake, decodes it, and sequences the sign-extension unit, ALU, register file, PC and data memory through fetch/decode/execute/memory/writeback states. The 3-bit immediate field goes to the sign-extension unit, which returns an 8-bit operand to the ALU.

## Interface
- No parameters; instruction width is fixed at 8 bits and immediate width at 3 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_req  out  1  instruction fetch request
- instr_ack  in  1  instruction memory has valid data
- instr_data  in  8  instruction word {opcode[7:5], rd[4:3], imm[2:0]}
- imm_bits  out  3  immediate field, drives sign-extension input
- alu_op  out  2  00 ADD, 01 AND, 10 OR, 11 PASS-B
- alu_src_imm  out  1  ALU B operand = sign-extended immediate
- zero_flag  in  1  registered ALU zero flag from the previous ALU op
- rf_addr  out  2  register file read/write address (rd)
- rf_we  out  1  register file write enable, one-cycle pulse
- rf_src_mem  out  1  writeback data select: 1 = dmem data, 0 = ALU result
- pc_inc  out  1  PC += 1, one-cycle pulse
- pc_add_imm  out  1  PC += sign-extended immediate, one-cycle pulse
- dmem_req  out  1  data memory request; address = r0 + sext(imm)
- dmem_we  out  1  data memory write qualifier, valid with dmem_req
- dmem_ack  in  1  data memory completed the access
- halted  out  1  processor halted

## Operation
- Opcodes: 000 ADDI rd += sext; 001 ANDI; 010 ORI; 011 LDI rd = sext; 100 LD rd = mem[r0+sext]; 101 ST mem[r0+sext] = rd; 110 BZ if zero_flag then PC += sext; 111 HALT if imm = 111, otherwise NOP.
- States: START, FETCH, DECODE, EXEC, MEM, WB, HALT. State register resets to START.
- START → FETCH unconditionally on the first edge after rst_n releases.
- FETCH: instr_req = 1. On an edge with instr_ack = 1, latch instr_data into IR, pulse pc_inc, and go to DECODE. Otherwise stay in FETCH.
- DECODE: imm_bits = IR[2:0] and rf_addr = IR[4:3]; these stay valid until the next FETCH. Next state:
  - EXEC for opcodes 000–100 and BZ.
  - MEM for ST.
  - HALT for 111 with imm = 111.
  - FETCH for 111 NOP.
- EXEC: alu_src_imm = 1 and alu_op is decoded from the opcode. LD uses ADD, for address generation only.
  - ALU ops and LDI go to WB.
  - LD goes to MEM.
  - BZ pulses pc_add_imm only if zero_flag = 1, then goes to FETCH.
- MEM: dmem_req = 1 and dmem_we = (opcode == ST). Stay in MEM until dmem_ack = 1. Then LD goes to WB and ST goes to FETCH.
- WB: rf_we = 1 for exactly one cycle, rf_src_mem = (opcode == LD), then go to FETCH.
- HALT: absorbing state with halted = 1 and all other outputs 0. Only reset exits it.
- Sign extension is combinational outside this block. The FSM must hold imm_bits stable from DECODE through the last cycle of the instruction.

## Timing
- Reset values while rst_n = 0 and in START: every output is 0, and IR = 8'h00.
- Reset is asynchronous at any state, including mid-handshake. Outputs drop to 0 immediately. No rf_we, pc_inc or dmem_req pulse completes.
- instr_req goes high one cycle after reset release and stays high until the ack edge. It is low in the cycle after the ack edge.
- Latency with zero-wait acks, counted from the first FETCH cycle to the next FETCH cycle:
  - ALU ops and LDI: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LD: 5 cycles.
  - ST: 3 cycles.
  - BZ: 3 cycles.
  - NOP: 2 cycles.
- Each memory wait cycle adds one cycle. The request holds steady while waiting.
- pc_inc and pc_add_imm are never asserted in the same cycle.
- An ack that arrives while its request is low is ignored.

## Test plan
- Reset then ADDI: reset with rst_n low, release it, serve 8'b000_01_011 with ack on the first FETCH cycle. Required: imm_bits = 3'b011, alu_op = 00, alu_src_imm = 1, and rf_we pulses once with rf_addr = 01 on cycle 4. pc_inc pulses on cycle 1 only.
- LD with wait states: serve 8'b100_10_101 and hold dmem_ack low for 3 cycles. Required: dmem_req high for 4 cycles with dmem_we = 0, then WB with rf_src_mem = 1 and rf_addr = 10. Total of 8 cycles.
- ST: serve 8'b101_11_100. Required: FETCH → DECODE → MEM with dmem_we = 1, no rf_we, and the next instr_req one cycle after dmem_ack.
- BZ negative offset: serve 8'b110_00_101.
  - With zero_flag = 1: pc_add_imm pulses once, and imm_bits = 101 (the sign-extension output is 8'hFD).
  - With zero_flag = 0: no pc_add_imm pulse.
- HALT versus NOP:
  - 8'hFF → halted = 1, and instr_req stays low for 20 cycles.
  - 8'hFE → FETCH resumes after 2 cycles.
- Reset mid-MEM: assert rst_n low while dmem_req is high. Required: dmem_req drops asynchronously, and after release the FSM goes START → FETCH with no rf_we pulse.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 8-bit datapath: fetch, decode, execute, memory and
// writeback sequencing of sign-extension, ALU, register file, PC and data memory.
module cpu_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    output logic       instr_req,
    input  logic       instr_ack,
    input  logic [7:0] instr_data,
    output logic [2:0] imm_bits,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    input  logic       zero_flag,
    output logic [1:0] rf_addr,
    output logic       rf_we,
    output logic       rf_src_mem,
    output logic       pc_inc,
    output logic       pc_add_imm,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       halted
);

    typedef enum logic [2:0] {
        StStart,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [2:0] OpAddi = 3'b000;
    localparam logic [2:0] OpAndi = 3'b001;
    localparam logic [2:0] OpOri  = 3'b010;
    localparam logic [2:0] OpLdi  = 3'b011;
    localparam logic [2:0] OpLd   = 3'b100;
    localparam logic [2:0] OpSt   = 3'b101;
    localparam logic [2:0] OpBz   = 3'b110;
    localparam logic [2:0] OpSys  = 3'b111;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluAnd   = 2'b01;
    localparam logic [1:0] AluOr    = 2'b10;
    localparam logic [1:0] AluPassB = 2'b11;

    state_e     state_q;
    logic [7:0] ir_q;
    logic [2:0] opcode;

    assign opcode = ir_q[7:5];

    // IR is cleared when entering FETCH or HALT, so the field outputs read 0 outside an
    // instruction and stay stable from DECODE through its last cycle.
    assign imm_bits = ir_q[2:0];
    assign rf_addr  = ir_q[4:3];

    // PC strobes are consumed on the edge that ends the current state.
    assign pc_inc     = (state_q == StFetch) && instr_ack;
    assign pc_add_imm = (state_q == StExec) && (opcode == OpBz) && zero_flag;

    function automatic logic [1:0] decode_alu_op(input logic [2:0] op);
        case (op)
            OpAndi:  decode_alu_op = AluAnd;
            OpOri:   decode_alu_op = AluOr;
            OpLdi:   decode_alu_op = AluPassB;
            default: decode_alu_op = AluAdd;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StStart;
            ir_q        <= 8'h00;
            instr_req   <= 1'b0;
            alu_op      <= AluAdd;
            alu_src_imm <= 1'b0;
            rf_we       <= 1'b0;
            rf_src_mem  <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_req   <= 1'b0;
            alu_op      <= AluAdd;
            alu_src_imm <= 1'b0;
            rf_we       <= 1'b0;
            rf_src_mem  <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            halted      <= 1'b0;
            case (state_q)
                StStart: begin
                    state_q   <= StFetch;
                    instr_req <= 1'b1;
                end
                StFetch: begin
                    if (instr_ack) begin
                        state_q <= StDecode;
                        ir_q    <= instr_data;
                    end else begin
                        instr_req <= 1'b1;
                    end
                end
                StDecode: begin
                    case (opcode)
                        OpSt: begin
                            state_q  <= StMem;
                            dmem_req <= 1'b1;
                            dmem_we  <= 1'b1;
                        end
                        OpSys: begin
                            ir_q <= 8'h00;
                            if (ir_q[2:0] == 3'b111) begin
                                state_q <= StHalt;
                                halted  <= 1'b1;
                            end else begin
                                state_q   <= StFetch;
                                instr_req <= 1'b1;
                            end
                        end
                        default: begin
                            state_q     <= StExec;
                            alu_src_imm <= 1'b1;
                            alu_op      <= decode_alu_op(opcode);
                        end
                    endcase
                end
                StExec: begin
                    case (opcode)
                        OpLd: begin
                            state_q  <= StMem;
                            dmem_req <= 1'b1;
                        end
                        OpBz: begin
                            state_q   <= StFetch;
                            instr_req <= 1'b1;
                            ir_q      <= 8'h00;
                        end
                        default: begin
                            state_q <= StWb;
                            rf_we   <= 1'b1;
                        end
                    endcase
                end
                StMem: begin
                    if (!dmem_ack) begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (opcode == OpSt);
                    end else if (opcode == OpLd) begin
                        state_q    <= StWb;
                        rf_we      <= 1'b1;
                        rf_src_mem <= 1'b1;
                    end else begin
                        state_q   <= StFetch;
                        instr_req <= 1'b1;
                        ir_q      <= 8'h00;
                    end
                end
                StWb: begin
                    state_q   <= StFetch;
                    instr_req <= 1'b1;
                    ir_q      <= 8'h00;
                end
                StHalt: begin
                    halted <= 1'b1;
                end
                default: begin
                    state_q <= StStart;
                    ir_q    <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed, table-driven bench for cpu_control_fsm: one vector per clock cycle, plus
// hand-written asynchronous reset sequences.
module tb_cpu_control_fsm;

    logic       clk;
    logic       rst_n;
    logic       instr_req;
    logic       instr_ack;
    logic [7:0] instr_data;
    logic [2:0] imm_bits;
    logic [1:0] alu_op;
    logic       alu_src_imm;
    logic       zero_flag;
    logic [1:0] rf_addr;
    logic       rf_we;
    logic       rf_src_mem;
    logic       pc_inc;
    logic       pc_add_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       halted;

    cpu_control_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_req   (instr_req),
        .instr_ack   (instr_ack),
        .instr_data  (instr_data),
        .imm_bits    (imm_bits),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .zero_flag   (zero_flag),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_src_mem  (rf_src_mem),
        .pc_inc      (pc_inc),
        .pc_add_imm  (pc_add_imm),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ack;
        logic [7:0]  data;
        logic        dack;
        logic        zf;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Packed order: req, imm[2:0], op[1:0], src, rfa[1:0], we, msrc, pinc, padd, dreq, dwe, hlt
    function automatic logic [15:0] o(input logic req, input logic [2:0] imm,
                                      input logic [1:0] op, input logic src,
                                      input logic [1:0] rfa, input logic we, input logic msrc,
                                      input logic pinc, input logic padd, input logic dreq,
                                      input logic dwe, input logic hlt);
        return {req, imm, op, src, rfa, we, msrc, pinc, padd, dreq, dwe, hlt};
    endfunction

    function automatic logic [15:0] outs();
        return {instr_req, imm_bits, alu_op, alu_src_imm, rf_addr, rf_we, rf_src_mem,
                pc_inc, pc_add_imm, dmem_req, dmem_we, halted};
    endfunction

    function automatic vec_t mk(input string name, input logic ack, input logic [7:0] data,
                                input logic dack, input logic zf, input logic [15:0] exp);
        vec_t v;
        v.name = name; v.ack = ack; v.data = data; v.dack = dack; v.zf = zf; v.exp = exp;
        return v;
    endfunction

    task automatic add(input string name, input logic ack, input logic [7:0] data,
                       input logic dack, input logic zf, input logic [15:0] exp);
        vecs.push_back(mk(name, ack, data, dack, zf, exp));
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h (req,imm,op,src,rfa,we,msrc,pinc,padd,dreq,dwe,hlt) expected %h",
                     name, act, exp);
        end
    endtask

    // Entered just after a rising edge; drives, samples on the falling edge, returns after
    // the next rising edge.
    task automatic run_vec(input vec_t v);
        instr_ack  = v.ack;
        instr_data = v.data;
        dmem_ack   = v.dack;
        zero_flag  = v.zf;
        @(negedge clk);
        check(v.name, outs(), v.exp);
        @(posedge clk);
        #1;
    endtask

    localparam logic [15:0] Z   = 16'h0000;
    localparam logic [15:0] HLT = 16'h0001;

    initial begin
        logic [15:0] fetch_ack;
        logic [15:0] fetch_idle;
        fetch_ack  = o(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        fetch_idle = o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        add("start", 0, 8'h00, 0, 0, Z);
        // ADDI r1 += 3
        add("addi_fetch",  1, 8'h0B, 0, 0, fetch_ack);
        add("addi_decode", 0, 8'h00, 0, 0, o(0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add("addi_exec",   0, 8'h00, 0, 0, o(0, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add("addi_wb",     0, 8'h00, 0, 0, o(0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        add("fetch_wait",  0, 8'h00, 1, 0, fetch_idle);
        // LD r2 = mem[r0-3] with three wait cycles; stray instr_ack while req low
        add("ld_fetch",    1, 8'h95, 0, 0, fetch_ack);
        add("ld_decode",   0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        add("ld_exec",     0, 8'h00, 0, 0, o(0, 5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        add("ld_mem_w1",   1, 8'hFF, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        add("ld_mem_w2",   0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        add("ld_mem_w3",   0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        add("ld_mem_ack",  0, 8'h00, 1, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        add("ld_wb",       0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));
        // ST mem[r0-4] = r3
        add("st_fetch",    1, 8'hBC, 0, 0, fetch_ack);
        add("st_decode",   0, 8'h00, 0, 0, o(0, 4, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        add("st_mem",      0, 8'h00, 1, 0, o(0, 4, 0, 0, 3, 0, 0, 0, 0, 1, 1, 0));
        // BZ -3, taken then not taken
        add("bz1_fetch",   1, 8'hC5, 0, 1, fetch_ack);
        add("bz1_decode",  0, 8'h00, 0, 1, o(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("bz1_exec",    0, 8'h00, 0, 1, o(0, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        add("bz0_fetch",   1, 8'hC5, 0, 0, fetch_ack);
        add("bz0_decode",  0, 8'h00, 0, 0, o(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("bz0_exec",    0, 8'h00, 0, 0, o(0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        // NOP (111 with imm 110)
        add("nop_fetch",   1, 8'hFE, 0, 0, fetch_ack);
        add("nop_decode",  0, 8'h00, 0, 0, o(0, 6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        // ORI r0 |= -1
        add("ori_fetch",   1, 8'h47, 0, 0, fetch_ack);
        add("ori_decode",  0, 8'h00, 0, 0, o(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ori_exec",    0, 8'h00, 0, 0, o(0, 7, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ori_wb",      0, 8'h00, 0, 0, o(0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // LDI r1 = 1
        add("ldi_fetch",   1, 8'h69, 0, 0, fetch_ack);
        add("ldi_decode",  0, 8'h00, 0, 0, o(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add("ldi_exec",    0, 8'h00, 0, 0, o(0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        add("ldi_wb",      0, 8'h00, 0, 0, o(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        // ANDI r2 &= 2
        add("andi_fetch",  1, 8'h32, 0, 0, fetch_ack);
        add("andi_decode", 0, 8'h00, 0, 0, o(0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
        add("andi_exec",   0, 8'h00, 0, 0, o(0, 2, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        add("andi_wb",     0, 8'h00, 0, 0, o(0, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0));
        // HALT
        add("halt_fetch",  1, 8'hFF, 0, 0, fetch_ack);
        add("halt_decode", 0, 8'h00, 0, 0, o(0, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) add("halt_hold", 1, 8'h0B, 1, 1, HLT);

        rst_n      = 1'b0;
        instr_ack  = 1'b0;
        instr_data = 8'h00;
        dmem_ack   = 1'b0;
        zero_flag  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset", outs(), Z);
        check("in_reset_ir", dut.ir_q, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Asynchronous reset out of HALT
        rst_n = 1'b0;
        #1;
        check("reset_from_halt", outs(), Z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of a pending LD memory access
        run_vec(mk("mm_start",  0, 8'h00, 0, 0, Z));
        run_vec(mk("mm_fetch",  1, 8'h95, 0, 0, fetch_ack));
        run_vec(mk("mm_decode", 0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0)));
        run_vec(mk("mm_exec",   0, 8'h00, 0, 0, o(0, 5, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0)));
        run_vec(mk("mm_mem",    0, 8'h00, 0, 0, o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0)));
        #2;
        check("mm_mem_still", outs(), o(0, 5, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0));
        rst_n = 1'b0;
        #1;
        check("mm_async_drop", outs(), Z);
        dmem_ack = 1'b1;
        @(posedge clk);
        #1;
        check("mm_held_reset", outs(), Z);
        rst_n = 1'b1;
        run_vec(mk("mm_restart", 0, 8'h00, 1, 0, Z));
        run_vec(mk("mm_refetch", 0, 8'h00, 1, 0, fetch_idle));
        run_vec(mk("mm_refetch2", 0, 8'h00, 0, 0, fetch_idle));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
